// File: rtl/datapath_arbiter.sv
// Two-requester datapath arbiter: round-robin grant, hold-time preemption with
// per-owner lock, owner-only bus steering, overflow routing and protocol-error pulses.
module datapath_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       lock0,
    input  logic       lock1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [3:0] src1_0,
    input  logic [3:0] src1_1,
    input  logic [3:0] src2_0,
    input  logic [3:0] src2_1,
    input  logic [3:0] dest0,
    input  logic [3:0] dest1,
    input  logic       overflow,
    output logic       gnt0,
    output logic       gnt1,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       ovf0,
    output logic       ovf1,
    output logic       busy,
    output logic       err0,
    output logic       err1
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rr_last;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_expired;

    // A waiter that shows up after the counter saturated still gets its turn.
    assign hold_expired = (hold_cnt >= HOLD_LAST);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = rr_last ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
            end
            OWN0: begin
                if (!req0)
                    state_nxt = req1 ? OWN1 : IDLE;
                else if (req1 && !lock0 && hold_expired)
                    state_nxt = OWN1;
            end
            OWN1: begin
                if (!req1)
                    state_nxt = req0 ? OWN0 : IDLE;
                else if (req0 && !lock1 && hold_expired)
                    state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            hold_cnt <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            busy     <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt0  <= (state_nxt == OWN0);
            gnt1  <= (state_nxt == OWN1);
            busy  <= (state_nxt != IDLE);
            err0  <= (op0 != 3'd0) && !gnt0;
            err1  <= (op1 != 3'd0) && !gnt1;
            if (state_nxt != state) begin
                hold_cnt <= '0;
                if (state_nxt == OWN0)
                    rr_last <= 1'b0;
                else if (state_nxt == OWN1)
                    rr_last <= 1'b1;
            end else if (state != IDLE && hold_cnt != HOLD_SAT) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    // Bus follows the owner only; IDLE (including during reset) presents a NOP.
    always_comb begin
        op   = 3'd0;
        src1 = 4'd0;
        src2 = 4'd0;
        dest = 4'd0;
        case (state)
            OWN0: begin
                op   = op0;
                src1 = src1_0;
                src2 = src2_0;
                dest = dest0;
            end
            OWN1: begin
                op   = op1;
                src1 = src1_1;
                src2 = src2_1;
                dest = dest1;
            end
            default: ;
        endcase
    end

    assign ovf0 = overflow & gnt0;
    assign ovf1 = overflow & gnt1;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Scoreboard bench for datapath_arbiter: stimulus pushes hand-computed output
// vectors, a negedge monitor pops and compares them against the DUT.
module tb_datapath_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
    logic [2:0] op0 = 0, op1 = 0;
    logic [3:0] src1_0 = 0, src1_1 = 0, src2_0 = 0, src2_1 = 0, dest0 = 0, dest1 = 0;
    logic       overflow = 0;
    logic       gnt0, gnt1, ovf0, ovf1, busy, err0, err1;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [21:0] vec;
    } exp_t;

    exp_t sb[$];

    datapath_arbiter #(.MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .op0(op0), .op1(op1),
        .src1_0(src1_0), .src1_1(src1_1), .src2_0(src2_0), .src2_1(src2_1),
        .dest0(dest0), .dest1(dest1), .overflow(overflow),
        .gnt0(gnt0), .gnt1(gnt1), .op(op), .src1(src1), .src2(src2), .dest(dest),
        .ovf0(ovf0), .ovf1(ovf1), .busy(busy), .err0(err0), .err1(err1)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Vector order: gnt0 gnt1 busy ovf0 ovf1 err0 err1 | op | src1 | src2 | dest
    task automatic expect_o(input string nm, input logic g0, input logic g1, input logic bz,
                            input logic o0, input logic o1, input logic e0, input logic e1,
                            input logic [2:0] eop, input logic [3:0] s1, input logic [3:0] s2,
                            input logic [3:0] d);
        exp_t e;
        e.name = nm;
        e.vec  = {g0, g1, bz, o0, o1, e0, e1, eop, s1, s2, d};
        sb.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [21:0] act;
            e   = sb.pop_front();
            act = {gnt0, gnt1, busy, ovf0, ovf1, err0, err1, op, src1, src2, dest};
            checks++;
            if (act !== e.vec) begin
                failures++;
                $display("FAIL %s actual=%h expected=%h", e.name, act, e.vec);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and its release
        nxt();
        expect_o("in_reset", 0,0,0,0,0,0,0, 0,0,0,0);
        #3 check("rst_hold_cnt", int'(dut.hold_cnt), 0);
        check("rst_rr_last", int'(dut.rr_last), 1);
        nxt();
        reset = 1'b0;
        expect_o("released", 0,0,0,0,0,0,0, 0,0,0,0);

        // Simultaneous first request goes to requester 0, then a bubble-free handover
        nxt();
        req0 = 1; req1 = 1;
        expect_o("a_req_sampled_next", 0,0,0,0,0,0,0, 0,0,0,0);
        nxt();
        req0 = 0;
        expect_o("a_gnt0_first", 1,0,1,0,0,0,0, 0,0,0,0);
        nxt();
        req1 = 0;
        expect_o("a_handover_gnt1", 0,1,1,0,0,0,0, 0,0,0,0);
        nxt();
        expect_o("a_idle", 0,0,0,0,0,0,0, 0,0,0,0);

        // Unlocked owner 0 preempted after MAX_HOLD cycles
        nxt();
        req0 = 1; req1 = 1;
        expect_o("b_idle", 0,0,0,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 8; i++) begin
            nxt();
            expect_o($sformatf("b_gnt0_%0d", i), 1,0,1,0,0,0,0, 0,0,0,0);
            #3 check($sformatf("b_hold_%0d", i), int'(dut.hold_cnt), i);
        end
        nxt();
        req0 = 0; req1 = 0;
        expect_o("b_preempt_gnt1", 0,1,1,0,0,0,0, 0,0,0,0);
        #3 check("b_hold_cleared", int'(dut.hold_cnt), 0);
        nxt();
        expect_o("b_idle_after", 0,0,0,0,0,0,0, 0,0,0,0);

        // Locked owner 0 is never preempted
        nxt();
        req0 = 1; req1 = 1; lock0 = 1;
        expect_o("c_idle", 0,0,0,0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 20; i++) begin
            nxt();
            if (i == 19) begin
                req0 = 0; lock0 = 0;
            end
            expect_o($sformatf("c_locked_gnt0_%0d", i), 1,0,1,0,0,0,0, 0,0,0,0);
        end

        // Owner 1 drives the bus; non-owner op raises err0; overflow routed to owner
        nxt();
        op1 = 3'd6; src1_1 = 4'd4; src2_1 = 4'd9; dest1 = 4'd10;
        op0 = 3'd3; src1_0 = 4'd1; src2_0 = 4'd2; dest0 = 4'd3;
        overflow = 1;
        expect_o("d_gnt1_bus", 0,1,1,0,1,0,0, 3'd6,4'd4,4'd9,4'd10);
        nxt();
        op0 = 0; overflow = 0;
        expect_o("d_err0_pulse", 0,1,1,0,0,1,0, 3'd6,4'd4,4'd9,4'd10);
        nxt();
        expect_o("d_err0_clear", 0,1,1,0,0,0,0, 3'd6,4'd4,4'd9,4'd10);

        // Reset mid-OWN1 forces NOP at once; first contested request after release goes to 0
        nxt();
        reset = 1'b1;
        expect_o("e_reset_async", 0,0,0,0,0,0,0, 0,0,0,0);
        #3 check("e_rst_rr_last", int'(dut.rr_last), 1);
        nxt();
        req0 = 1; req1 = 1; overflow = 1;
        expect_o("e_reset_held", 0,0,0,0,0,0,0, 0,0,0,0);
        nxt();
        reset = 1'b0;
        expect_o("e_released", 0,0,0,0,0,0,0, 0,0,0,0);
        nxt();
        op1 = 0; req0 = 0; req1 = 0;
        expect_o("e_gnt0_err1_ovf0", 1,0,1,1,0,0,1, 3'd0,4'd1,4'd2,4'd3);
        nxt();
        expect_o("e_idle", 0,0,0,0,0,0,0, 0,0,0,0);

        nxt();
        nxt();
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath_arbiter.md
DATAPATH_ARBITER -- requirements
Module: datapath_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 8, the number of cycles an unlocked owner may hold the datapath while the other requester waits; legal range 2..255.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-high reset.
- req0 / req1  in  1  requester wants the datapath.
- lock0 / lock1  in  1  owner forbids preemption, for multi-op sequences.
- op0 / op1  in  3  requester operation code; 0 = NOP.
- src1_0 / src1_1, src2_0 / src2_1, dest0 / dest1  in  4  requester register addresses.
- overflow  in  1  datapath overflow flag.
- gnt0 / gnt1  out  1  requester currently owns the datapath.
- op  out  3  operation to the datapath.
- src1, src2, dest  out  4  addresses to the datapath.
- ovf0 / ovf1  out  1  overflow routed to the owner.
- busy  out  1  some requester owns the datapath.
- err0 / err1  out  1  protocol-violation pulse.

Function
REQ-004 The block SHALL implement states IDLE, OWN0 and OWN1; gnt0 SHALL equal (state==OWN0) and gnt1 SHALL equal (state==OWN1), both registered.
REQ-005 The block SHALL keep a round-robin pointer rr_last, meaning the last granted requester; it SHALL update on every entry into OWN0 or OWN1.
REQ-006 In IDLE, req0 alone SHALL go to OWN0 and req1 alone SHALL go to OWN1; when both are requesting, the requester not equal to rr_last SHALL win; with no request the state SHALL stay IDLE.
REQ-007 Grant latency SHALL be one cycle: a request sampled at edge N gives gnt high after edge N.
REQ-008 In OWNx, when reqx is low at an edge: if the other requester is requesting, the state SHALL go directly to the other OWN state with no IDLE bubble; otherwise it SHALL go to IDLE.
REQ-009 In OWNx with reqx high, lockx low, the other requester requesting and hold_cnt == MAX_HOLD-1, the block SHALL preempt to the other OWN state.
REQ-010 When lockx is high, the block SHALL never preempt; the owner SHALL keep the grant until reqx falls.
REQ-011 hold_cnt SHALL be $clog2(MAX_HOLD+1) bits wide and SHALL clear on every state change.
REQ-012 hold_cnt SHALL increment each cycle in OWN0/OWN1 and saturate at MAX_HOLD.
REQ-013 The datapath bus outputs (op, src1, src2, dest) SHALL be driven combinationally from the owner's inputs in OWNx, and SHALL be all zeros (NOP) in IDLE.
REQ-014 The non-owner's op, src and dest inputs SHALL never reach the datapath bus.
REQ-015 The block SHALL drive ovfx = overflow & gntx, and busy = (state != IDLE).
REQ-016 errx SHALL be a one-cycle registered pulse, set when at an edge opx != 0 while gntx is low.
REQ-017 errx SHALL not be sticky.
REQ-018 A requester dropping reqx and raising it again in the same cycle as the other requester's release SHALL be arbitrated by REQ-006 rules applied to the transition.

Reset
REQ-019 While reset is high, regardless of the clock: state SHALL be IDLE, rr_last SHALL be 1, hold_cnt SHALL be 0, gnt0/gnt1/err0/err1/busy SHALL be 0, and op/src1/src2/dest/ovf0/ovf1 SHALL be 0.
REQ-020 Reset asserted during an owned sequence SHALL force NOP onto the bus immediately; after release, the first simultaneous request SHALL go to requester 0.

Verification
REQ-021 Reset, then req0=req1=1 at the same edge -> gnt0=1 after one cycle; after req0 drops -> gnt1=1 on the next edge with busy held at 1.
REQ-022 req0 held with lock0=0, req1 asserted, MAX_HOLD=8 -> gnt0 for exactly 8 cycles, then gnt1=1 and hold_cnt=0.
REQ-023 Same stimulus as REQ-022 with lock0=1 for 20 cycles -> gnt0 stays 1 for all 20 cycles; gnt1 rises one edge after req0 falls.
REQ-024 Owner 1 with op1=6, src1_1=4, src2_1=9, dest1=10, while op0=3 -> bus shows 6/4/9/10; err0 pulses one cycle; overflow=1 gives ovf1=1 and ovf0=0.
REQ-025 Reset asserted mid-OWN1 with op1=6 -> op=0 and gnt1=0 within the same cycle; after release, req0=req1=1 -> gnt0 granted first.
